// File: rtl/dwt_pkg.sv
// Shared definitions for the 5/3 lifting line engine.
// - dwt_state_e  : controller state encoding
// - MODE_FWD/INV : values of the mode input
// - acc_t        : wide signed accumulator for lifting sums
// - predict_term : (a+b)>>>1, update_term : (a+b+2)>>>2 (floor semantics)
package dwt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPass1,
    StPass2,
    StOut
  } dwt_state_e;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Wide enough that DATA_W+2-bit sums never overflow for DATA_W up to 32, so the
  // truncated results match a DATA_W+2 datapath exactly.
  localparam int unsigned ACC_W = 34;
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t predict_term(acc_t a, acc_t b);
    return (a + b) >>> 1;
  endfunction

  function automatic acc_t update_term(acc_t a, acc_t b);
    return (a + b + acc_t'(2)) >>> 2;
  endfunction

endpackage

// File: rtl/dwt_pair_ram.sv
// Line store for the lifting engine: two PAIRS x DATA_W arrays (even and odd),
// one shared write port and three read ports at rd_idx-1, rd_idx, rd_idx+1.
// Neighbour indices clamp at the line ends, which yields the symmetric extension
// even[PAIRS] = even[PAIRS-1] and d[-1] = d[0].
// Ports: clk; we/wr_idx/wr_even/wr_odd write a pair; rd_idx selects the centre;
// {even,odd}_{prev,cur,next} are the asynchronous read results.
module dwt_pair_ram #(
  parameter int DATA_W = 16,
  parameter int PAIRS  = 32,
  parameter int IDX_W  = 5
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic signed [DATA_W-1:0] wr_even,
  input  logic signed [DATA_W-1:0] wr_odd,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic signed [DATA_W-1:0] even_prev,
  output logic signed [DATA_W-1:0] even_cur,
  output logic signed [DATA_W-1:0] even_next,
  output logic signed [DATA_W-1:0] odd_prev,
  output logic signed [DATA_W-1:0] odd_cur,
  output logic signed [DATA_W-1:0] odd_next
);

  logic signed [DATA_W-1:0] even_mem [PAIRS];
  logic signed [DATA_W-1:0] odd_mem  [PAIRS];
  logic [IDX_W-1:0]         prev_idx;
  logic [IDX_W-1:0]         next_idx;

  assign prev_idx = (rd_idx == '0) ? '0 : rd_idx - IDX_W'(1);
  assign next_idx = (rd_idx == IDX_W'(PAIRS - 1)) ? rd_idx : rd_idx + IDX_W'(1);

  // Contents are never cleared; an aborted line is simply overwritten.
  always_ff @(posedge clk) begin
    if (we) begin
      even_mem[wr_idx] <= wr_even;
      odd_mem[wr_idx]  <= wr_odd;
    end
  end

  assign even_prev = even_mem[prev_idx];
  assign even_cur  = even_mem[rd_idx];
  assign even_next = even_mem[next_idx];
  assign odd_prev  = odd_mem[prev_idx];
  assign odd_cur   = odd_mem[rd_idx];
  assign odd_next  = odd_mem[next_idx];

endmodule

// File: rtl/lifting_dwt_line.sv
// 1-D reversible 5/3 lifting engine for one line (forward or inverse).
// Loads PAIRS even/odd pairs, runs two in-place lifting passes of PAIRS cycles
// each, then streams the result pairs out under valid/ready backpressure.
// Ports: clk, rst (sync, active high); mode/line_address latched on the first
// pair; in_valid/in_ready/in_even/in_odd input stream; out_valid/out_ready/
// out_even/out_odd/out_last/out_address output stream; busy when not idle.
module lifting_dwt_line
  import dwt_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int PAIRS   = 32,
  parameter int LINE_AW = 8,
  localparam int IDX_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1,
  localparam int ADDR_W = LINE_AW + $clog2(PAIRS) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [LINE_AW-1:0]       line_address,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_even,
  input  logic signed [DATA_W-1:0] in_odd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_even,
  output logic signed [DATA_W-1:0] out_odd,
  output logic                     out_last,
  output logic [ADDR_W-1:0]        out_address,
  output logic                     busy
);

  dwt_state_e               state_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     mode_q;
  logic [ADDR_W-1:0]        base_q;
  logic                     in_ready_q, out_valid_q, out_last_q;
  logic signed [DATA_W-1:0] out_even_q, out_odd_q;
  logic [ADDR_W-1:0]        out_address_q;

  logic                     we;
  logic [IDX_W-1:0]         wr_idx;
  logic signed [DATA_W-1:0] wr_even, wr_odd;
  logic signed [DATA_W-1:0] ev_p, ev_c, ev_n, od_p, od_c, od_n;
  logic                     unused_ev_p;

  acc_t                     pred, upd, even_acc, odd_acc;
  logic signed [DATA_W-1:0] pair_even, pair_odd;
  logic                     even_pass;
  logic                     in_hs;

  dwt_pair_ram #(
    .DATA_W (DATA_W),
    .PAIRS  (PAIRS),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk       (clk),
    .we        (we),
    .wr_idx    (wr_idx),
    .wr_even   (wr_even),
    .wr_odd    (wr_odd),
    .rd_idx    (idx_q),
    .even_prev (ev_p),
    .even_cur  (ev_c),
    .even_next (ev_n),
    .odd_prev  (od_p),
    .odd_cur   (od_c),
    .odd_next  (od_n)
  );

  assign unused_ev_p = ^ev_p;
  assign in_hs       = in_valid & in_ready_q;

  // Both lifting terms are always available; the pass/mode pick which array is rewritten.
  assign pred     = predict_term(acc_t'(ev_c), acc_t'(ev_n));
  assign upd      = update_term(acc_t'(od_p), acc_t'(od_c));
  assign even_acc = (mode_q == MODE_INV) ? acc_t'(ev_c) - upd  : acc_t'(ev_c) + upd;
  assign odd_acc  = (mode_q == MODE_INV) ? acc_t'(od_c) + pred : acc_t'(od_c) - pred;

  always_comb begin
    // Forward: PASS1 rewrites odd (d), PASS2 rewrites even (s). Inverse is the mirror.
    even_pass = (state_q == StPass1) ? (mode_q == MODE_INV) : (mode_q == MODE_FWD);
    pair_even = even_pass ? even_acc[DATA_W-1:0] : ev_c;
    pair_odd  = even_pass ? od_c : odd_acc[DATA_W-1:0];
    we        = 1'b0;
    wr_idx    = idx_q;
    wr_even   = in_even;
    wr_odd    = in_odd;
    unique case (state_q)
      StIdle: begin
        we     = in_hs;
        wr_idx = '0;
      end
      StLoad: we = in_hs;
      StPass1, StPass2: begin
        we      = 1'b1;
        wr_even = pair_even;
        wr_odd  = pair_odd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      mode_q        <= MODE_FWD;
      base_q        <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_even_q    <= '0;
      out_odd_q     <= '0;
      out_address_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          in_ready_q <= 1'b1;
          if (in_hs) begin
            mode_q  <= mode;
            base_q  <= ADDR_W'(line_address) * ADDR_W'(2 * PAIRS);
            idx_q   <= IDX_W'(1);
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (in_hs) begin
            if (idx_q == IDX_W'(PAIRS - 1)) begin
              idx_q      <= '0;
              in_ready_q <= 1'b0;
              state_q    <= StPass1;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        StPass1: begin
          if (idx_q == IDX_W'(PAIRS - 1)) begin
            idx_q   <= '0;
            state_q <= StPass2;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StPass2: begin
          // Pair 0 is final once PASS2 writes it; capture it so OUT can start at once.
          if (idx_q == '0) begin
            out_even_q <= pair_even;
            out_odd_q  <= pair_odd;
          end
          if (idx_q == IDX_W'(PAIRS - 1)) begin
            idx_q         <= '0;
            out_valid_q   <= 1'b1;
            out_last_q    <= 1'b0;
            out_address_q <= base_q;
            state_q       <= StOut;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        StOut: begin
          if (out_ready) begin
            if (idx_q == IDX_W'(PAIRS - 1)) begin
              idx_q       <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= StIdle;
            end else begin
              // The n+1 read port supplies the next pair.
              idx_q         <= idx_q + IDX_W'(1);
              out_even_q    <= ev_n;
              out_odd_q     <= od_n;
              out_address_q <= out_address_q + ADDR_W'(2);
              out_last_q    <= (idx_q == IDX_W'(PAIRS - 2));
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_even    = out_even_q;
  assign out_odd     = out_odd_q;
  assign out_address = out_address_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_lifting_dwt_line.sv
module tb_lifting_dwt_line;

  localparam int DATA_W  = 16;
  localparam int PAIRS   = 32;
  localparam int LINE_AW = 8;
  localparam int ADDR_W  = LINE_AW + $clog2(PAIRS) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, mode, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [LINE_AW-1:0]       line_address;
  logic signed [DATA_W-1:0] in_even, in_odd, out_even, out_odd;
  logic [ADDR_W-1:0]        out_address;

  lifting_dwt_line #(
    .DATA_W  (DATA_W),
    .PAIRS   (PAIRS),
    .LINE_AW (LINE_AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .line_address (line_address),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_even      (in_even),
    .in_odd       (in_odd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_even     (out_even),
    .out_odd      (out_odd),
    .out_last     (out_last),
    .out_address  (out_address),
    .busy         (busy)
  );

  typedef struct {
    logic signed [DATA_W-1:0] e;
    logic signed [DATA_W-1:0] o;
    logic                     last;
    logic [ADDR_W-1:0]        addr;
  } exp_t;

  exp_t                     exp_q[$];
  logic signed [DATA_W-1:0] cap_e[$], cap_o[$];
  logic signed [DATA_W-1:0] vec_e[PAIRS], vec_o[PAIRS], ref_e[PAIRS], ref_o[PAIRS];
  logic signed [DATA_W-1:0] org_e[PAIRS], org_o[PAIRS];
  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout, required DUT event within bound", name);
  endtask

  // Monitor: pops the scoreboard on every output handshake, and checks that a stalled
  // pair stays stable until it is accepted.
  logic                     held = 1'b0;
  logic signed [DATA_W-1:0] h_e, h_o;
  logic                     h_l;
  logic [ADDR_W-1:0]        h_a;
  exp_t                     mx;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_even", out_even, h_e);
          check("hold_odd", out_odd, h_o);
          check("hold_last", 16'(out_last), 16'(h_l));
          check("hold_addr", 16'(out_address), 16'(h_a));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_pair: got pair at addr %0d, required none", out_address);
          end else begin
            mx = exp_q.pop_front();
            check("out_even", out_even, mx.e);
            check("out_odd", out_odd, mx.o);
            check("out_last", 16'(out_last), 16'(mx.last));
            check("out_address", 16'(out_address), 16'(mx.addr));
          end
          cap_e.push_back(out_even);
          cap_o.push_back(out_odd);
        end
        held = out_valid && !out_ready;
        h_e  = out_even;
        h_o  = out_odd;
        h_l  = out_last;
        h_a  = out_address;
      end
    end
  end

  // Mode and line_address are inverted after the first pair: they must be ignored.
  task automatic send_pairs(input logic m, input logic [LINE_AW-1:0] la, input int count);
    for (int i = 0; i < count; i++) begin
      int   t;
      logic hs;
      t            = 0;
      hs           = 1'b0;
      in_valid     = 1'b1;
      in_even      = vec_e[i];
      in_odd       = vec_o[i];
      mode         = (i == 0) ? m : ~m;
      line_address = (i == 0) ? la : ~la;
      while (!hs && t < 200) begin
        @(negedge clk);
        hs = in_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!hs) begin
        timeout_fail("in_handshake");
        i = count;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic push_expected(input int la);
    exp_t x;
    for (int n = 0; n < PAIRS; n++) begin
      x.e    = ref_e[n];
      x.o    = ref_o[n];
      x.last = (n == PAIRS - 1);
      x.addr = ADDR_W'(la * 2 * PAIRS + 2 * n);
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q.size() != 0) timeout_fail("drain");
    exp_q.delete();
  endtask

  // Reference forward transform with symmetric extension and floor shifts.
  task automatic model_forward();
    int d[PAIRS];
    int a, b, s;
    for (int n = 0; n < PAIRS; n++) begin
      a    = vec_e[n];
      b    = vec_e[(n == PAIRS - 1) ? n : n + 1];
      d[n] = int'(vec_o[n]) - ((a + b) >>> 1);
    end
    for (int n = 0; n < PAIRS; n++) begin
      a        = d[(n == 0) ? 0 : n - 1];
      s        = int'(vec_e[n]) + ((a + d[n] + 2) >>> 2);
      ref_e[n] = DATA_W'(s);
      ref_o[n] = DATA_W'(d[n]);
    end
  endtask

  initial begin
    int t;
    rst          = 1'b1;
    mode         = 1'b0;
    line_address = '0;
    in_valid     = 1'b0;
    in_even      = '0;
    in_odd       = '0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;

    // Constant line: d = 0, s = 100.
    for (int n = 0; n < PAIRS; n++) begin
      vec_e[n] = 16'sd100; vec_o[n] = 16'sd100; ref_e[n] = 16'sd100; ref_o[n] = 16'sd0;
    end
    push_expected(0);
    send_pairs(1'b0, 8'd0, PAIRS);
    wait_drain();

    // Ramp: only the last d sees the extension; s = even.
    for (int n = 0; n < PAIRS; n++) begin
      vec_e[n] = DATA_W'(2 * n); vec_o[n] = DATA_W'(2 * n + 1);
      ref_e[n] = DATA_W'(2 * n); ref_o[n] = (n == PAIRS - 1) ? 16'sd1 : 16'sd0;
    end
    push_expected(1);
    send_pairs(1'b0, 8'd1, PAIRS);
    wait_drain();

    // Negative floor: even = -1, odd = 0 -> d = 1, s = 0. Garbage held on in_valid
    // through the passes, then a 3-cycle stall on pair 2.
    for (int n = 0; n < PAIRS; n++) begin
      vec_e[n] = -16'sd1; vec_o[n] = 16'sd0; ref_e[n] = 16'sd0; ref_o[n] = 16'sd1;
    end
    push_expected(2);
    send_pairs(1'b0, 8'd2, PAIRS);
    in_valid = 1'b1;
    in_even  = 16'sh7fff;
    in_odd   = 16'sh1234;
    repeat (PAIRS) @(posedge clk);
    #1;
    check("in_ready_pass", 16'(in_ready), 16'd0);
    check("busy_pass", 16'(busy), 16'd1);
    repeat (PAIRS - 2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = 0;
    while (!(out_valid && out_address == ADDR_W'(2 * 2 * PAIRS + 4)) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) timeout_fail("reach_pair2");
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Abort after 5 pairs.
    for (int n = 0; n < PAIRS; n++) begin
      vec_e[n] = DATA_W'(7 * n - 50); vec_o[n] = DATA_W'(3 - 5 * n);
    end
    send_pairs(1'b0, 8'd9, 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", 16'(in_ready), 16'd0);
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_out_last", 16'(out_last), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_out_even", out_even, 16'd0);
    check("abort_out_odd", out_odd, 16'd0);
    check("abort_out_address", 16'(out_address), 16'd0);
    rst = 1'b0;
    model_forward();
    push_expected(4);
    send_pairs(1'b0, 8'd4, PAIRS);
    wait_drain();

    // Round trip: forward then inverse must reconstruct the line exactly.
    for (int l = 0; l < 50; l++) begin
      for (int n = 0; n < PAIRS; n++) begin
        vec_e[n] = DATA_W'(int'($urandom_range(16000)) - 8000);
        vec_o[n] = DATA_W'(int'($urandom_range(16000)) - 8000);
        org_e[n] = vec_e[n];
        org_o[n] = vec_o[n];
      end
      model_forward();
      cap_e.delete();
      cap_o.delete();
      push_expected(3);
      send_pairs(1'b0, 8'd3, PAIRS);
      wait_drain();
      for (int n = 0; n < PAIRS; n++) begin
        vec_e[n] = (n < cap_e.size()) ? cap_e[n] : '0;
        vec_o[n] = (n < cap_o.size()) ? cap_o[n] : '0;
        ref_e[n] = org_e[n];
        ref_o[n] = org_o[n];
      end
      push_expected(3);
      send_pairs(1'b1, 8'd3, PAIRS);
      wait_drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lifting_dwt_line.md
Name: lifting_dwt_line

Overview:
- Parametrised 1-D reversible 5/3 integer lifting engine for one image line, supporting both forward (analysis) and inverse (synthesis) transforms.
- Consumes even/odd sample pairs over a valid/ready stream and buffers the whole line internally.
- Runs the predict and update passes with symmetric boundary extension, then streams low/high coefficient pairs out under backpressure.
- Sits between the line buffer/frame memory and the coefficient coder; row and column passes both reuse it.

Parameters:
- DATA_W, 16: signed coefficient width on all data ports and in internal storage; results wrap modulo 2^DATA_W.
- PAIRS, 32: even/odd pairs per line (line length 2*PAIRS); must be at least 2.
- LINE_AW, 8: width of the line index used for address generation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = forward, 1 = inverse; sampled on the first accepted pair of a line.
- line_address  in  LINE_AW  line index; sampled with mode.
- in_valid  in  1  input pair valid.
- in_ready  out  1  block can accept a pair.
- in_even  in  DATA_W  even sample (forward) or low coefficient s (inverse).
- in_odd  in  DATA_W  odd sample (forward) or high coefficient d (inverse).
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the pair.
- out_even  out  DATA_W  s[n] (forward) or reconstructed even sample (inverse).
- out_odd  out  DATA_W  d[n] (forward) or reconstructed odd sample (inverse).
- out_last  out  1  high with the final pair of the line.
- out_address  out  LINE_AW+log2(PAIRS)+1  line_address*2*PAIRS + 2n; the odd sample lives at +1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, busy=0, out_even=0, out_odd=0, out_address=0. The FSM returns to IDLE and all counters clear.
- Reset during any state aborts the line. Buffered data is discarded without being cleared.
- States and transitions:
  - IDLE: in_ready=1. The first handshake latches mode and line_address, stores pair 0, and moves to LOAD.
  - LOAD: in_ready=1. Each handshake stores the pair at the current load index. After pair PAIRS-1 is stored, in_ready falls on the next cycle and the FSM moves to PASS1.
  - PASS1 (PAIRS cycles, index n=0..PAIRS-1):
    - Forward: d[n] = odd[n] - (even[n]+even[n+1])>>>1.
    - Inverse: e[n] = s[n] - (d[n-1]+d[n]+2)>>>2.
  - PASS2 (PAIRS cycles):
    - Forward: s[n] = even[n] + (d[n-1]+d[n]+2)>>>2.
    - Inverse: o[n] = d[n] + (e[n]+e[n+1])>>>1.
  - OUT: presents pair n. It advances only on out_valid && out_ready. out_last is asserted for n=PAIRS-1; after that handshake the FSM returns to IDLE.
- Boundaries (symmetric extension): even[PAIRS] := even[PAIRS-1] (likewise e[PAIRS]), and d[-1] := d[0].
- Arithmetic:
  - All sums are computed at DATA_W+2 bits.
  - >>> is an arithmetic shift, i.e. floor division, including for negative values.
  - Results are truncated to DATA_W bits.
- Each pass writes in place. Pass ordering guarantees that every operand read is already final for that pass.
- Latency: 2*PAIRS cycles from the cycle after the last input handshake to the first out_valid.
- OUT with out_ready held low: out_even, out_odd, out_address and out_last stay stable.
- in_valid during PASS1, PASS2 or OUT is ignored because in_ready=0.
- A mode change mid-line has no effect until the next line.

Decomposition:
- Shared package dwt_pkg holds:
  - the state encoding (IDLE, LOAD, PASS1, PASS2, OUT);
  - MODE_FWD and MODE_INV constants;
  - functions predict_term(a,b) = (a+b)>>>1 and update_term(a,b) = (a+b+2)>>>2.
- One sub-module, dwt_pair_ram: a dual-array PAIRS x DATA_W register file with one write port and three read ports (n-1, n, n+1), with index clamping for boundary extension done inside it.

Test Plan:
- Forward, PAIRS=8, constant line with every sample 100 -> all d=0, all s=100; out_last only on pair 7; out_address 0,2,..,14 for line 0.
- Forward, PAIRS=8, ramp even[n]=2n, odd[n]=2n+1 -> d[0..6]=0, d[7]=1; s[n]=2n for every n.
- Forward negative rounding: even[n]=-1, odd[n]=0 -> every d=1, every s=0. This checks floor behaviour on negatives.
- Round trip: 50 random lines (DATA_W=16, PAIRS=32, inputs within ±8000) forward, then fed back in inverse -> bit-exact reconstruction. Use line_address=3 and check out_address base = 192.
- Backpressure: drop out_ready for 3 cycles at pair 2 -> outputs stable, no pair lost or duplicated. Hold in_valid high during PASS1 -> no writes.
- Reset: assert rst for 1 cycle after 5 pairs are loaded -> next cycle all outputs are at reset values; a following full line produces correct results.
